// File: rtl/tx_inject.sv
// Packet injector: holds a host-loaded packet until the gap predictor grants a slot,
// then splices it into a fixed-latency pass-through of the observed line stream.
module tx_inject #(
    parameter int PAW     = 11,
    parameter int LATENCY = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           host_wr_en,
    input  logic [PAW-1:0] host_wr_addr,
    input  logic [7:0]     host_wr_data,
    input  logic [PAW-1:0] host_len,
    input  logic           host_go,
    output logic           host_busy,
    output logic           host_done,
    output logic           request_to_send,
    output logic [PAW-1:0] tx_packet_width,
    input  logic           clear_to_send,
    input  logic [7:0]     rx_d,
    input  logic           rx_dv,
    output logic [7:0]     out_d,
    output logic           out_dv,
    output logic           collision
);

    typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           mem [2**PAW];
    logic [7:0]           rd_data_p0;
    logic [PAW-1:0]       rd_addr;
    logic [PAW-1:0]       cnt;
    logic                 accept;
    logic                 last;
    logic                 send;
    logic [7:0]           pass_d_p [LATENCY];
    logic [LATENCY-1:0]   pass_dv_p;

    assign accept = (state == IDLE) && host_go && (host_len != '0);
    assign last   = (cnt == tx_packet_width - PAW'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = ARMED;
            ARMED:   if (clear_to_send) state_nxt = SEND;
            SEND:    if (last)          state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Read address runs one byte ahead of the output slot so the 1-cycle RAM read lines up.
    always_comb begin
        request_to_send = (state == ARMED);
        host_busy       = (state != IDLE);
        send            = (state == SEND);
        rd_addr         = send ? cnt + PAW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_packet_width <= '0;
            cnt             <= '0;
            host_done       <= 1'b0;
            collision       <= 1'b0;
        end else begin
            if (accept)
                tx_packet_width <= host_len;
            cnt       <= send ? cnt + PAW'(1) : '0;
            host_done <= send && last;
            if (send && pass_dv_p[LATENCY-1])
                collision <= 1'b1;
        end
    end

    // Stage p0: packet buffer, host writes locked out while a packet is in flight.
    always_ff @(posedge clk) begin
        if (host_wr_en && !host_busy)
            mem[host_wr_addr] <= host_wr_data;
        rd_data_p0 <= mem[rd_addr];
    end

    // Stage p0..pLATENCY-1: pass-through delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_dv_p <= '0;
            for (int i = 0; i < LATENCY; i++)
                pass_d_p[i] <= '0;
        end else begin
            pass_dv_p[0] <= rx_dv;
            pass_d_p[0]  <= rx_d;
            for (int i = 1; i < LATENCY; i++) begin
                pass_dv_p[i] <= pass_dv_p[i-1];
                pass_d_p[i]  <= pass_d_p[i-1];
            end
        end
    end

    assign out_dv = send | pass_dv_p[LATENCY-1];
    assign out_d  = send ? rd_data_p0 : pass_d_p[LATENCY-1];

endmodule

// File: tb/tb_tx_inject.sv
// Directed bench for tx_inject: injection timing, pass-through latency, ignored commands,
// collision handling, grant drop and mid-packet reset.
module tb_tx_inject;

    localparam int PAW = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic           host_wr_en;
    logic [PAW-1:0] host_wr_addr;
    logic [7:0]     host_wr_data;
    logic [PAW-1:0] host_len;
    logic           host_go;
    logic           host_busy;
    logic           host_done;
    logic           request_to_send;
    logic [PAW-1:0] tx_packet_width;
    logic           clear_to_send;
    logic [7:0]     rx_d;
    logic           rx_dv;
    logic [7:0]     out_d;
    logic           out_dv;
    logic           collision;

    int errors = 0;
    int checks = 0;

    tx_inject #(.PAW(PAW), .LATENCY(10)) dut (
        .clk(clk), .rst(rst),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_len(host_len), .host_go(host_go), .host_busy(host_busy), .host_done(host_done),
        .request_to_send(request_to_send), .tx_packet_width(tx_packet_width),
        .clear_to_send(clear_to_send), .rx_d(rx_d), .rx_dv(rx_dv),
        .out_d(out_d), .out_dv(out_dv), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            host_wr_en   = 1'b1;
            host_wr_addr = PAW'(i);
            host_wr_data = 8'(base + i);
            tick();
        end
        host_wr_en = 1'b0;
    endtask

    task automatic arm(input int len);
        host_len = PAW'(len);
        host_go  = 1'b1;
        tick();
        host_go  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({host_busy, host_done, request_to_send, out_dv, collision} !== 5'b0)
            $display("FAIL reset_ctrl busy/done/rts/dv/col got %b want 00000",
                     {host_busy, host_done, request_to_send, out_dv, collision});
        if ({host_busy, host_done, request_to_send, out_dv, collision} !== 5'b0) errors++;
        checks++;
        if (out_d !== 8'h00 || tx_packet_width !== '0) begin
            errors++;
            $display("FAIL reset_data out_d=%h width=%0d want 00 and 0", out_d, tx_packet_width);
        end
        rst = 1'b0;
    endtask

    task automatic test_inject();
        load_bytes(8'h10, 5);
        arm(5);
        checks++;
        if ({host_busy, request_to_send} !== 2'b11 || tx_packet_width !== PAW'(5)) begin
            errors++;
            $display("FAIL inject_armed busy/rts=%b width=%0d want 11 and 5",
                     {host_busy, request_to_send}, tx_packet_width);
        end
        clear_to_send = 1'b1;
        tick();
        clear_to_send = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_dv !== 1'b1 || out_d !== 8'(8'h10 + k) || request_to_send !== 1'b0 || host_done !== 1'b0) begin
                errors++;
                $display("FAIL inject_byte%0d dv=%b d=%h rts=%b done=%b want 1 %h 0 0",
                         k, out_dv, out_d, request_to_send, host_done, 8'(8'h10 + k));
            end
            tick();
        end
        checks++;
        if ({host_done, host_busy, out_dv, collision} !== 4'b1000) begin
            errors++;
            $display("FAIL inject_done done/busy/dv/col=%b want 1000",
                     {host_done, host_busy, out_dv, collision});
        end
        tick();
        checks++;
        if (host_done !== 1'b0) begin
            errors++;
            $display("FAIL inject_done_pulse done=%b want 0", host_done);
        end
    endtask

    task automatic test_passthrough();
        for (int t = 0; t < 28; t++) begin
            logic exp_dv;
            rx_dv  = (t < 16);
            rx_d   = 8'(8'hA0 + t);
            exp_dv = (t >= 10 && t < 26);
            checks++;
            if (out_dv !== exp_dv || (exp_dv && out_d !== 8'(8'hA0 + t - 10))) begin
                errors++;
                $display("FAIL pass_t%0d dv=%b d=%h want dv=%b d=%h",
                         t, out_dv, out_d, exp_dv, 8'(8'hA0 + t - 10));
            end
            tick();
        end
        rx_dv = 1'b0;
    endtask

    task automatic test_ignore();
        clear_to_send = 1'b1;
        tick();
        clear_to_send = 1'b0;
        checks++;
        if ({host_busy, request_to_send, out_dv} !== 3'b000) begin
            errors++;
            $display("FAIL cts_in_idle busy/rts/dv=%b want 000", {host_busy, request_to_send, out_dv});
        end
        arm(0);
        checks++;
        if ({host_busy, request_to_send} !== 2'b00 || tx_packet_width !== PAW'(5)) begin
            errors++;
            $display("FAIL zero_len busy/rts=%b width=%0d want 00 and 5",
                     {host_busy, request_to_send}, tx_packet_width);
        end
        arm(2);
        checks++;
        if (tx_packet_width !== PAW'(2) || request_to_send !== 1'b1) begin
            errors++;
            $display("FAIL arm2 width=%0d rts=%b want 2 and 1", tx_packet_width, request_to_send);
        end
        host_len     = PAW'(3);
        host_go      = 1'b1;
        host_wr_en   = 1'b1;
        host_wr_addr = '0;
        host_wr_data = 8'hEE;
        tick();
        host_go    = 1'b0;
        host_wr_en = 1'b0;
        checks++;
        if (tx_packet_width !== PAW'(2) || {host_busy, request_to_send} !== 2'b11) begin
            errors++;
            $display("FAIL go_while_busy width=%0d busy/rts=%b want 2 and 11",
                     tx_packet_width, {host_busy, request_to_send});
        end
        clear_to_send = 1'b1;
        tick();
        clear_to_send = 1'b0;
        checks++;
        if (out_dv !== 1'b1 || out_d !== 8'h10) begin
            errors++;
            $display("FAIL write_while_busy dv=%b d=%h want 1 10", out_dv, out_d);
        end
        tick();
        checks++;
        if (out_dv !== 1'b1 || out_d !== 8'h11) begin
            errors++;
            $display("FAIL short_byte1 dv=%b d=%h want 1 11", out_dv, out_d);
        end
        tick();
        checks++;
        if ({host_done, host_busy, out_dv} !== 3'b100) begin
            errors++;
            $display("FAIL short_done done/busy/dv=%b want 100", {host_done, host_busy, out_dv});
        end
    endtask

    task automatic test_collision();
        load_bytes(8'h30, 3);
        arm(3);
        for (int t = 0; t < 25; t++) begin
            rx_dv         = (t < 20);
            rx_d          = 8'(8'hB0 + t);
            clear_to_send = (t == 12);
            if (t == 11) begin
                checks++;
                if (out_dv !== 1'b1 || out_d !== 8'hB1 || collision !== 1'b0) begin
                    errors++;
                    $display("FAIL col_pre dv=%b d=%h col=%b want 1 B1 0", out_dv, out_d, collision);
                end
            end
            if (t >= 13 && t <= 15) begin
                checks++;
                if (out_dv !== 1'b1 || out_d !== 8'(8'h30 + t - 13)) begin
                    errors++;
                    $display("FAIL col_inject_t%0d dv=%b d=%h want 1 %h",
                             t, out_dv, out_d, 8'(8'h30 + t - 13));
                end
            end
            if (t == 13 || t == 14) begin
                checks++;
                if (collision !== (t == 14)) begin
                    errors++;
                    $display("FAIL col_flag_t%0d col=%b want %b", t, collision, (t == 14));
                end
            end
            if (t == 16) begin
                checks++;
                if ({host_done, out_dv} !== 2'b11 || out_d !== 8'hB6) begin
                    errors++;
                    $display("FAIL col_resume done/dv=%b d=%h want 11 B6", {host_done, out_dv}, out_d);
                end
            end
            if (t == 24) begin
                checks++;
                if (collision !== 1'b1) begin
                    errors++;
                    $display("FAIL col_sticky col=%b want 1", collision);
                end
            end
            tick();
        end
        clear_to_send = 1'b0;
        rx_dv         = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({collision, out_dv} !== 2'b00) begin
            errors++;
            $display("FAIL col_clear col/dv=%b want 00", {collision, out_dv});
        end
    endtask

    task automatic test_cts_drop_and_abort();
        load_bytes(8'h50, 7);
        arm(7);
        clear_to_send = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            if (k == 1) clear_to_send = 1'b0;
            checks++;
            if (out_dv !== 1'b1 || out_d !== 8'(8'h50 + k)) begin
                errors++;
                $display("FAIL drop_byte%0d dv=%b d=%h want 1 %h", k, out_dv, out_d, 8'(8'h50 + k));
            end
            tick();
        end
        checks++;
        if ({host_done, host_busy} !== 2'b10) begin
            errors++;
            $display("FAIL drop_done done/busy=%b want 10", {host_done, host_busy});
        end
        load_bytes(8'h60, 7);
        arm(7);
        clear_to_send = 1'b1;
        tick();
        clear_to_send = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_dv !== 1'b1 || out_d !== 8'(8'h60 + k)) begin
                errors++;
                $display("FAIL abort_byte%0d dv=%b d=%h want 1 %h", k, out_dv, out_d, 8'(8'h60 + k));
            end
            if (k < 4) tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({out_dv, host_busy, host_done, request_to_send} !== 4'b0000) begin
            errors++;
            $display("FAIL abort dv/busy/done/rts=%b want 0000",
                     {out_dv, host_busy, host_done, request_to_send});
        end
        rst = 1'b0;
        arm(2);
        checks++;
        if ({host_busy, host_done} !== 2'b10 || tx_packet_width !== PAW'(2)) begin
            errors++;
            $display("FAIL go_after_rst busy/done=%b width=%0d want 10 and 2",
                     {host_busy, host_done}, tx_packet_width);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (host_done !== 1'b0 || request_to_send !== 1'b1) begin
            errors++;
            $display("FAIL no_stray_done done=%b rts=%b want 0 1", host_done, request_to_send);
        end
    endtask

    initial begin
        host_wr_en    = 1'b0;
        host_wr_addr  = '0;
        host_wr_data  = '0;
        host_len      = '0;
        host_go       = 1'b0;
        clear_to_send = 1'b0;
        rx_d          = '0;
        rx_dv         = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_inject();
        test_passthrough();
        test_ignore();
        test_collision();
        test_cts_drop_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_inject.md
TX_INJECT -- requirements
Module: tx_inject

Interface
REQ-001 Parameter PAW, default 11, width of packet length and buffer address; buffer depth 2^PAW bytes.
REQ-002 Parameter LATENCY, default 10, pass-through delay in cycles from rx_* to out_*; SHALL match the LATENCY of the gap predictor granting clear_to_send.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 host_wr_en  in  1  buffer byte write strobe.
REQ-006 host_wr_addr  in  PAW  buffer write address.
REQ-007 host_wr_data  in  8  buffer write data.
REQ-008 host_len  in  PAW  packet length in bytes, sampled on accepted host_go.
REQ-009 host_go  in  1  single-cycle start pulse.
REQ-010 host_busy  out  1  high from accepted host_go until packet fully sent.
REQ-011 host_done  out  1  single-cycle pulse on cycle after last injected byte.
REQ-012 request_to_send  out  1  to gap predictor; packet pending.
REQ-013 tx_packet_width  out  PAW  to gap predictor; latched packet length.
REQ-014 clear_to_send  in  1  from gap predictor; slot granted.
REQ-015 rx_d  in  8, rx_dv  in  1  line stream observed by the scanner.
REQ-016 out_d  out  8, out_dv  out  1  merged output stream.
REQ-017 collision  out  1  sticky error flag.

Function
REQ-018 States: IDLE, ARMED, SEND; no other states reachable.
REQ-019 IDLE: host_go with host_len != 0 latches host_len into tx_packet_width, goes ARMED next cycle; host_go with host_len == 0 ignored.
REQ-020 host_go while host_busy high ignored; latched length unchanged.
REQ-021 host_wr_en writes buffer only when host_busy low; writes while busy dropped.
REQ-022 ARMED: request_to_send = 1; buffer read address held at 0 so byte 0 is ready on grant.
REQ-023 ARMED and clear_to_send = 1 (cycle c0): enter SEND at c0+1; request_to_send = 0 from c0+1.
REQ-024 SEND: out_d = buffer[k], out_dv = 1 at cycle c0+1+k, k = 0..tx_packet_width-1; bytes consecutive, no gaps.
REQ-025 SEND length governed by internal counter only; clear_to_send level ignored once in SEND (early drop or extended high has no effect).
REQ-026 After last byte: IDLE at c0+1+tx_packet_width, host_done pulses that cycle, host_busy low same cycle.
REQ-027 Pass-through: outside SEND output slots, out_d/out_dv = rx_d/rx_dv delayed exactly LATENCY cycles.
REQ-028 Injected byte has priority; a delayed pass-through byte with dv = 1 coinciding with an injected slot is dropped and collision set to 1.
REQ-029 collision sticky; cleared only by rst.
REQ-030 clear_to_send in IDLE or SEND ignored.
REQ-031 tx_packet_width stable from accept until IDLE re-entered.
REQ-032 Buffer: simple dual-port, 1-cycle synchronous read; write/read same address same cycle returns old data (not reachable in normal use, writes blocked while busy).

Reset
REQ-033 rst sampled high: next cycle state IDLE, request_to_send 0, host_busy 0, host_done 0, out_dv 0, out_d 0, collision 0, tx_packet_width 0, delay line cleared (dv bits 0).
REQ-034 rst mid-SEND aborts packet: out_dv 0 next cycle, no host_done pulse; buffer contents not required cleared.
REQ-035 First accepted host_go is the cycle after rst deasserts.

Verification
REQ-036 Load bytes 0x10..0x14, host_len = 5, host_go; grant clear_to_send at c0 -> out_d 0x10..0x14 at c0+1..c0+5 with out_dv 1, host_done at c0+6, collision 0.
REQ-037 rx_dv/rx_d stream 0xA0..0xAF, no injection -> identical bytes on out_* exactly 10 cycles later.
REQ-038 host_go with host_len = 0, and second host_go while ARMED with host_len = 3 -> no state change, tx_packet_width stays at first value.
REQ-039 Force clear_to_send during live delayed traffic -> injected bytes appear, overlapping pass-through bytes dropped, collision = 1 until rst.
REQ-040 clear_to_send drops after 2 cycles of a 7-byte packet -> all 7 bytes still sent; rst asserted at byte 4 of a later packet -> out_dv 0 next cycle, host_busy 0, no host_done.
